// File: rtl/mmss_timer_ctrl.sv
// MM:SS stopwatch controller for the VGA digit painter.
// Run/pause/clear FSM, 1 Hz prescaler, BCD counter with 59:59 -> 00:00 wrap,
// and a display latch that only updates on the vsync falling edge.
// Optional feature: define TIMER_BLINK_EN to blank the digits (4'hF) for the
// second half of each blink period while paused.
module mmss_timer_ctrl #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       vsync,
  output logic [3:0] mDecimal,
  output logic [3:0] mUnit,
  output logic [3:0] sDecimal,
  output logic [3:0] sUnit,
  output logic       running,
  output logic       rollover
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q;
  logic            tick;
  logic [3:0]      md_q, mu_q, sd_q, su_q;
  logic [3:0]      md_d, mu_d, sd_d, su_d;
  logic            wrap;
  logic            rollover_q;
  logic            vsync_q;
  logic            vfall;
  logic            blank;
  logic [3:0]      disp_md_q, disp_mu_q, disp_sd_q, disp_su_q;

  // Next-state logic: clear dominates start, start toggles run/pause.
  always_comb begin
    state_d = state_q;
    if (btn_clear) begin
      state_d = StIdle;
    end else if (btn_start) begin
      case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign running = (state_q == StRun);
  assign tick    = (state_q == StRun) && (pre_q == PreMax);

  // Prescaler: counts only in RUN, holds in PAUSE so partial seconds survive.
  always_ff @(posedge clk) begin
    if (reset || btn_clear) begin
      pre_q <= '0;
    end else if (state_q == StRun) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

  // BCD cascade; wrap flags the 59:59 -> 00:00 transition.
  always_comb begin
    md_d = md_q;
    mu_d = mu_q;
    sd_d = sd_q;
    su_d = su_q;
    wrap = 1'b0;
    if (tick) begin
      if (su_q != 4'd9) begin
        su_d = su_q + 4'd1;
      end else begin
        su_d = 4'd0;
        if (sd_q != 4'd5) begin
          sd_d = sd_q + 4'd1;
        end else begin
          sd_d = 4'd0;
          if (mu_q != 4'd9) begin
            mu_d = mu_q + 4'd1;
          end else begin
            mu_d = 4'd0;
            if (md_q != 4'd5) begin
              md_d = md_q + 4'd1;
            end else begin
              md_d = 4'd0;
              wrap = 1'b1;
            end
          end
        end
      end
    end
  end

  // Internal count and rollover pulse registers.
  always_ff @(posedge clk) begin
    if (reset || btn_clear) begin
      md_q       <= 4'd0;
      mu_q       <= 4'd0;
      sd_q       <= 4'd0;
      su_q       <= 4'd0;
      rollover_q <= 1'b0;
    end else begin
      md_q       <= md_d;
      mu_q       <= mu_d;
      sd_q       <= sd_d;
      su_q       <= su_d;
      rollover_q <= wrap;
    end
  end

  assign rollover = rollover_q;

  // vsync delay for falling-edge detection; idles high like the real sync.
  always_ff @(posedge clk) begin
    if (reset) vsync_q <= 1'b1;
    else       vsync_q <= vsync;
  end

  assign vfall = vsync_q & ~vsync;

`ifdef TIMER_BLINK_EN
  logic [PreW-1:0] blink_q;

  // Free-running blink phase, restarted on entry to PAUSE so blanking starts visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= '0;
    end else if ((state_d == StPause) && (state_q != StPause)) begin
      blink_q <= '0;
    end else begin
      blink_q <= (blink_q == PreMax) ? '0 : blink_q + 1'b1;
    end
  end

  assign blank = (state_q == StPause) && (blink_q >= PreW'(TICK_DIV / 2));
`else
  assign blank = 1'b0;
`endif

  // Display latch: frame-synchronous, except clear which zeroes immediately.
  always_ff @(posedge clk) begin
    if (reset || btn_clear) begin
      disp_md_q <= 4'd0;
      disp_mu_q <= 4'd0;
      disp_sd_q <= 4'd0;
      disp_su_q <= 4'd0;
    end else if (vfall) begin
      disp_md_q <= blank ? 4'hF : md_q;
      disp_mu_q <= blank ? 4'hF : mu_q;
      disp_sd_q <= blank ? 4'hF : sd_q;
      disp_su_q <= blank ? 4'hF : su_q;
    end
  end

  assign mDecimal = disp_md_q;
  assign mUnit    = disp_mu_q;
  assign sDecimal = disp_sd_q;
  assign sUnit    = disp_su_q;

endmodule
